// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit for the memory stage.
//
// Takes the ALU result as the effective address, plus store data and
// size/sign controls. Runs one req/gnt/rvalid transaction on the data
// memory port and returns an aligned, extended load result (or an error)
// to writeback.
//
// Optional build macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word ops complete with rsp_err, no access
//   undefined : low address bits are masked for half/word; only size 11 errors
//
// Ports
//   clk, rst_n                 clock / async active-low reset
//   req_valid, req_ready       request handshake from decode/ALU
//   req_we, req_size,          store flag, size (00 B, 01 H, 10 W, 11 illegal),
//   req_unsigned               zero-extend loads
//   req_addr, req_wdata,       effective address, store data,
//   req_rd                     destination register
//   mem_req/gnt/addr/we/be/    data-memory request channel
//   mem_wdata
//   mem_rvalid, mem_rdata      read data / write acknowledge
//   rsp_valid/rdata/rd/err     one-cycle completion to writeback
//   busy                       unit not idle
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | ready for a new op
// REQ   | mem_req asserted, address/data held until mem_gnt
// WAIT  | granted, waiting for mem_rvalid (read data or write ack)
// RESP  | rsp_valid pulse for one cycle

module lsu_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [REG_AW-1:0] req_rd,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [REG_AW-1:0] rsp_rd,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [REG_AW-1:0] rd_q;
   logic              err_q;
   logic [XLEN-1:0]   rdata_q;

   logic              accept;
   logic              req_err;
   logic [1:0]        off;
   logic [3:0]        be;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_ext;

   assign accept = req_valid && (state_q == IDLE);

   // Error decode on the incoming request, evaluated at accept time.
   always_comb begin
      req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
      if (req_size == 2'b01 && req_addr[0])
         req_err = 1'b1;
      if (req_size == 2'b10 && (req_addr[1:0] != 2'b00))
         req_err = 1'b1;
`endif
   end

   // Byte offset of the captured op. Without the alignment check the
   // low bits that cannot be honoured are simply dropped.
   always_comb begin
      off = addr_q[1:0];
`ifndef LSU_MISALIGN_CHECK_EN
      if (size_q == 2'b01)
         off = {addr_q[1], 1'b0};
      else if (size_q == 2'b10)
         off = 2'b00;
`endif
   end

   always_comb begin
      case (size_q)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00:   wdata_rep = {4{wdata_q[7:0]}};
         2'b01:   wdata_rep = {2{wdata_q[15:0]}};
         default: wdata_rep = wdata_q;
      endcase
   end

   assign shifted = mem_rdata >> {off, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   load_ext = {{(XLEN-8){shifted[7] & ~uns_q}}, shifted[7:0]};
         2'b01:   load_ext = {{(XLEN-16){shifted[15] & ~uns_q}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            err_q   <= req_err;
            rdata_q <= '0;
         end else if (state_q == WAIT && mem_rvalid) begin
            rdata_q <= we_q ? '0 : load_ext;
         end
      end
   end

   // Next state and outputs. Memory and response outputs are gated by
   // state so that they read 0 whenever the unit is not in that phase.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_rd    = '0;
      rsp_err   = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_d = req_err ? RESP : REQ;
         end
         REQ: begin
            mem_req   = 1'b1;
            mem_addr  = {addr_q[XLEN-1:2], 2'b00};
            mem_we    = we_q;
            mem_be    = be;
            mem_wdata = wdata_rep;
            if (mem_gnt)
               state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid)
               state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_rd    = rd_q;
            rsp_err   = err_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
      .rsp_err(rsp_err), .busy(busy)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          gdly;
      int          rdly;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rsp;
      logic        e_err;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: derive the memory-side view and the response from the
   // size/offset rules with plain arithmetic.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata,
                        output logic [31:0] e_addr, output logic [3:0] e_be,
                        output logic [31:0] e_wdata, output logic [31:0] e_rsp,
                        output logic e_err);
      int nb;
      int o;
      longint val;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      o  = int'(addr % 4);
      e_err = (size == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
      if (size != 2'd3 && (addr % nb) != 0) e_err = 1'b1;
`else
      if (size != 2'd3) o = o - (o % nb);
`endif
      e_addr = addr - (addr % 4);
      e_be   = 4'(((1 << nb) - 1) << o);
      e_wdata = '0;
      for (int i = 0; i < 4; i++)
         e_wdata = e_wdata | (((wdata >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      if (we || e_err) begin
         e_rsp = '0;
      end else begin
         val = (longint'(rdata) >> (8 * o)) & ((64'd1 << (8 * nb)) - 1);
         if (!uns && nb < 4 && val >= (64'd1 << (8 * nb - 1)))
            val = val - (64'd1 << (8 * nb));
         e_rsp = val[31:0];
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int reqcnt, waitcnt, exp_lat;
      logic granted, done;
      reqcnt = 0; waitcnt = 0; granted = 1'b0; done = 1'b0;
      exp_lat = v.e_err ? 1 : 3 + v.gdly + v.rdly;
      @(negedge clk);
      chk({tag, " ready_idle"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
      @(posedge clk);
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_addr  = $urandom;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (rsp_valid) begin
            chk({tag, " latency"}, cyc, exp_lat);
            chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rsp);
            chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, v.e_err});
            chk({tag, " rsp_rd"}, {27'd0, rsp_rd}, {27'd0, v.rd});
            done = 1'b1;
         end else begin
            chk({tag, " not_ready"}, {31'd0, req_ready}, 32'd0);
            if (mem_req) begin
               if (v.e_err) chk({tag, " no_mem_on_err"}, 32'd1, 32'd0);
               if (reqcnt == 0 || reqcnt == v.gdly) begin
                  chk({tag, " mem_addr"}, mem_addr, v.e_addr);
                  chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.e_be});
                  chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
                  if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
               end
               reqcnt++;
               mem_rvalid = 1'($urandom);   // must be ignored in REQ
               if (reqcnt > v.gdly) begin
                  mem_gnt = 1'b1;
                  granted = 1'b1;
               end
            end else if (granted) begin
               waitcnt++;
               mem_gnt = 1'($urandom);      // must be ignored in WAIT
               if (waitcnt > v.rdly) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = v.rdata;
               end
            end
         end
         @(posedge clk);
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL %s timeout: no rsp_valid within 60 cycles", tag);
      end
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk({tag, " rsp_pulse_once"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic [31:0] rdata,
                               input int gdly, input int rdly,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic [31:0] e_rsp,
                               input logic e_err);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rd = rd; v.rdata = rdata; v.gdly = gdly; v.rdly = rdly;
      v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rsp = e_rsp;
      v.e_err = e_err;
      return v;
   endfunction

   initial begin
      vec_t v;
      tbl[0] = mk(0, 2'd2, 0, 32'h100, 32'h0, 5'd1, 32'hDEADBEEF, 0, 0,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
      tbl[1] = mk(0, 2'd0, 0, 32'h103, 32'h55, 5'd2, 32'h80FF0000, 0, 0,
                  32'h100, 4'b1000, 32'h55555555, 32'hFFFFFF80, 0);
      tbl[2] = mk(0, 2'd0, 1, 32'h103, 32'h55, 5'd3, 32'h80FF0000, 0, 0,
                  32'h100, 4'b1000, 32'h55555555, 32'h00000080, 0);
      tbl[3] = mk(1, 2'd1, 0, 32'h202, 32'h1234ABCD, 5'd4, 32'hFFFFFFFF, 0, 2,
                  32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
      tbl[4] = mk(0, 2'd2, 0, 32'h101, 32'h0, 5'd5, 32'h11223344, 0, 0,
                  32'h100, 4'b1111, 32'h0, 32'h0, 1);
`else
      tbl[4] = mk(0, 2'd2, 0, 32'h101, 32'h0, 5'd5, 32'h11223344, 0, 0,
                  32'h100, 4'b1111, 32'h0, 32'h11223344, 0);
`endif
      tbl[5] = mk(0, 2'd1, 0, 32'h002, 32'h0, 5'd6, 32'h80017FFF, 5, 0,
                  32'h000, 4'b1100, 32'h0, 32'hFFFF8001, 0);
      tbl[6] = mk(0, 2'd3, 0, 32'h000, 32'h0, 5'd7, 32'h12345678, 0, 0,
                  32'h000, 4'b0000, 32'h0, 32'h0, 1);
      tbl[7] = mk(0, 2'd1, 1, 32'h000, 32'h0, 5'd8, 32'h00008001, 1, 1,
                  32'h000, 4'b0011, 32'h0, 32'h00008001, 0);
      tbl[8] = mk(1, 2'd0, 0, 32'h001, 32'h000000AB, 5'd9, 32'h0, 0, 0,
                  32'h000, 4'b0010, 32'hABABABAB, 32'h0, 0);

      #12;
      chk("reset req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset outputs", {mem_req, mem_we, mem_be, rsp_valid, rsp_err, busy, rsp_rd},
          32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_op(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         v.we = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
         v.addr = $urandom; v.wdata = $urandom; v.rd = 5'($urandom);
         v.rdata = $urandom; v.gdly = $urandom_range(0, 3); v.rdly = $urandom_range(0, 3);
         model(v.we, v.size, v.uns, v.addr, v.wdata, v.rdata,
               v.e_addr, v.e_be, v.e_wdata, v.e_rsp, v.e_err);
         run_op(v, $sformatf("rnd%0d", i));
      end

      // Reset in WAIT: outputs clear at once; a late rvalid is ignored.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40; req_rd = 5'd17;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst mem_req in REQ", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("rst busy in WAIT", {30'd0, busy, mem_req}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst async outputs", {mem_req, mem_we, mem_be, rsp_valid, rsp_err, busy, rsp_rd},
          32'd0);
      chk("rst async mem_addr", mem_addr, 32'd0);
      chk("rst async mem_wdata", mem_wdata, 32'd0);
      chk("rst async rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst late rvalid no rsp", {30'd0, rsp_valid, busy}, 32'd0);
      end
      mem_rvalid = 1'b0;

      run_op(tbl[0], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit in the memory stage, directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data and size/sign controls from the decoder.
- Runs one request/grant/response transaction on the data-memory port.
- Returns an aligned, sign- or zero-extended load result, or an error, to writeback.

Parameters:
- XLEN, 32: data/address width; taken from riscv_pkg; only 32 supported.
- REG_AW, 5: destination register index width.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: a memory op is offered.
- req_ready, out, 1: unit can accept an op.
- req_we, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, in, 1: zero-extend the load (LBU/LHU).
- req_addr, in, XLEN: effective address (ALU result).
- req_wdata, in, XLEN: store data (rs2).
- req_rd, in, REG_AW: load destination register.
- mem_req, out, 1: memory request.
- mem_gnt, in, 1: memory accepts the request.
- mem_addr, out, XLEN: word-aligned address.
- mem_we, out, 1: write enable.
- mem_be, out, 4: byte enables.
- mem_wdata, out, XLEN: lane-replicated store data.
- mem_rvalid, in, 1: read data / write acknowledge.
- mem_rdata, in, XLEN: read word.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, XLEN: extended load data.
- rsp_rd, out, REG_AW: destination register.
- rsp_err, out, 1: misaligned or illegal-size op.
- busy, out, 1: state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset forces state IDLE and drives every output 0 except req_ready = 1. Captured request registers clear to 0.
- States: IDLE, REQ, WAIT, RESP.
- req_ready = (state == IDLE).
- IDLE:
  - On req_valid & req_ready, capture all req_* fields.
  - If the op is misaligned or illegal, set err and go to RESP; no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt.
  - On mem_gnt go to WAIT; mem_req drops the next cycle.
  - mem_gnt is ignored outside REQ.
- WAIT:
  - On mem_rvalid, register the extended data and go to RESP.
  - Stores also wait for mem_rvalid as the write acknowledge.
  - mem_rvalid is ignored outside WAIT.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - No backpressure on the response.
- Minimum latency from accept to rsp_valid:
  - 3 cycles with gnt in the first REQ cycle and rvalid in the first WAIT cycle.
  - 1 cycle for an error.
- Alignment:
  - Byte: always legal.
  - Half: legal only if addr[0] = 0.
  - Word: legal only if addr[1:0] = 00.
  - Size 11: always an error.
- mem_addr = {addr[XLEN-1:2], 2'b00}. Let o = addr[1:0].
- mem_be:
  - byte: 0001 << o.
  - half: 0011 << o.
  - word: 1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction:
  - s = mem_rdata >> (8*o).
  - byte: extend s[7:0]; half: extend s[15:0]; word: s.
  - Sign extension unless req_unsigned.
- Response contents:
  - rsp_rdata = 0 for stores and for errors.
  - rsp_rd is echoed for all ops.
  - rsp_err = 1 only on an error completion.
- Reset mid-operation aborts the transaction immediately. mem_req falls asynchronously; a later gnt/rvalid is ignored because it arrives in IDLE.
- req_valid while busy is not accepted; the upstream holds the request.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned half/word raises rsp_err as above, with no memory access.
- Undefined:
  - No alignment check.
  - Half uses o = {addr[1], 1'b0}; word uses o = 00, i.e. the low address bits are silently masked.
  - Only size 11 raises rsp_err.

Test Plan:
- LW at 0x100, mem_rdata = 0xDEADBEEF, gnt and rvalid immediate:
  - mem_addr = 0x100, mem_be = 1111.
  - rsp_valid exactly 3 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- LB at 0x103, rdata = 0x80FF0000:
  - rsp_rdata = 0xFFFFFF80.
- LBU at the same address:
  - rsp_rdata = 0x00000080.
- SH at 0x202, wdata = 0x1234ABCD:
  - mem_addr = 0x200, mem_be = 1100, mem_wdata = 0xABCDABCD, mem_we = 1.
  - rsp_valid after rvalid, rsp_rdata = 0.
- LW at 0x101 with LSU_MISALIGN_CHECK_EN:
  - mem_req never asserts; rsp_valid 1 cycle after accept with rsp_err = 1.
- LW at 0x101 without the macro:
  - mem_addr = 0x100, normal load, rsp_err = 0.
- mem_gnt held low 5 cycles:
  - mem_req and address stay stable; req_ready = 0 throughout; completion follows gnt.
- rst_n pulled low during WAIT:
  - All outputs 0 and req_ready = 1 immediately; a late mem_rvalid produces no rsp_valid.
